// File: rtl/score_display_pkg.sv
// score_display_pkg: shared FSM state, segment codes and sizing for the score display.
package score_display_pkg;
  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
  localparam int NUM_DIGITS = 4;
  localparam int CONV_ITERS = 14;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    return d == 4'd0 ? SEG_0 : d == 4'd1 ? SEG_1 : d == 4'd2 ? SEG_2 :
           d == 4'd3 ? SEG_3 : d == 4'd4 ? SEG_4 : d == 4'd5 ? SEG_5 :
           d == 4'd6 ? SEG_6 : d == 4'd7 ? SEG_7 : d == 4'd8 ? SEG_8 :
           d == 4'd9 ? SEG_9 : SEG_BLANK;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one shift per clk; done pulses after the last shift.
module bin2bcd_seq
  import score_display_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [13:0] bin_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] bcd_o
);
  logic [13:0] sr_q;
  logic [15:0] acc_q;
  logic [15:0] adj;
  logic [3:0]  iter_q;
  logic        busy_q;
  logic        done_q;

  for (genvar i = 0; i < 4; i++) begin : g_adj
    assign adj[4*i +: 4] = acc_q[4*i +: 4] >= 4'd5 ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q   <= '0;
      acc_q  <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        sr_q   <= bin_i;
        acc_q  <= '0;
        iter_q <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        {acc_q, sr_q} <= {adj, sr_q} << 1;
        iter_q        <= iter_q + 4'd1;
        if (iter_q == 4'(CONV_ITERS - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = acc_q;
endmodule

// File: rtl/score_display.sv
// score_display: converts the game score to BCD and scans it onto a 4-digit
// active-low seven-segment display with leading-zero blanking and overflow dp.
module score_display
  import score_display_pkg::*;
#(
  parameter int          REFRESH_DIV = 100000,
  parameter logic [15:0] SAT_MAX     = 16'd9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] score_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [15:0] bcd_out,
  output logic        busy
);
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;

  state_t                 state_q;
  logic [15:0]            last_q;
  logic [15:0]            bcd_q;
  logic                   ovf_q;
  logic                   ovf_pend_q;
  logic                   busy_q;
  logic [1:0]             sel_q;
  logic [CW-1:0]          cnt_q;
  logic [NUM_DIGITS-1:0]  an_q;
  logic [6:0]             seg_q;
  logic                   dp_q;
  logic                   start;
  logic                   conv_busy;
  logic                   conv_done;
  logic [15:0]            conv_bcd;
  logic [13:0]            sat;
  logic                   wrap;
  logic                   lz;
  logic [6:0]             digit_seg;

  // Scores changing mid-conversion are picked up once we are back in IDLE.
  assign start     = state_q == IDLE && !conv_busy && score_in != last_q;
  assign sat       = score_in > SAT_MAX ? SAT_MAX[13:0] : score_in[13:0];
  assign wrap      = cnt_q == CW'(REFRESH_DIV - 1);
  assign lz        = sel_q == 2'd3 ? bcd_q[15:12] == 4'd0 :
                     sel_q == 2'd2 ? bcd_q[15:8] == 8'd0 :
                     sel_q == 2'd1 ? bcd_q[15:4] == 12'd0 : 1'b0;
  assign digit_seg = lz ? SEG_BLANK : seg_enc(bcd_q[{sel_q, 2'b00} +: 4]);

  bin2bcd_seq u_conv (
    .clk     (clk),
    .reset   (reset),
    .start_i (start),
    .bin_i   (sat),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      sel_q      <= '0;
      cnt_q      <= '0;
      an_q       <= '1;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
    end else begin
      cnt_q <= wrap ? '0 : cnt_q + CW'(1);
      if (wrap) sel_q <= sel_q + 2'd1;
      an_q  <= ~(4'b0001 << sel_q);
      seg_q <= digit_seg;
      dp_q  <= !(sel_q == 2'd0 && ovf_q);
      case (state_q)
        IDLE: if (start) begin
          last_q     <= score_in;
          ovf_pend_q <= score_in > SAT_MAX;
          busy_q     <= 1'b1;
          state_q    <= CONV;
        end
        CONV: if (conv_done) begin
          busy_q  <= 1'b0;
          state_q <= LOAD;
        end
        LOAD: begin
          bcd_q   <= conv_bcd;
          ovf_q   <= ovf_pend_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign an      = an_q;
  assign seg     = seg_q;
  assign dp      = dp_q;
  assign bcd_out = bcd_q;
  assign busy    = busy_q;
endmodule

// File: tb/tb_score_display.sv
// tb_score_display: table-driven conversions with a bcd_out scoreboard, scan
// pattern checking, and hand sequences for mid-conversion changes and reset.
module tb_score_display;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] score_in = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [15:0] bcd_out;
  logic        busy;

  typedef struct {
    logic [15:0] score;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  int          total = 0;
  int          passed = 0;
  logic [15:0] sb_q[$];
  logic [15:0] prev_bcd = '0;
  logic        busy_d = 1'b0;
  logic        pend = 1'b0;
  logic [6:0]  segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  vec_t        vecs [10];

  score_display #(.REFRESH_DIV(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .score_in (score_in),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .bcd_out  (bcd_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passed++;
  endfunction

  function automatic int dec(input logic [3:0] a);
    return a == 4'b1110 ? 0 : a == 4'b1101 ? 1 : a == 4'b1011 ? 2 : a == 4'b0111 ? 3 : -1;
  endfunction

  // Scoreboard: one bcd_out comparison one clk after each busy fall.
  always @(negedge clk) begin
    if (pend) begin
      if (sb_q.size() == 0) begin
        total++;
        $display("FAIL sb_underflow: conversion completed with bcd_out %h but none expected", bcd_out);
      end else chk("bcd_out", bcd_out, sb_q.pop_front());
    end
    pend   <= !reset && busy_d && !busy;
    busy_d <= busy;
  end

  task automatic convert(input logic [15:0] s, input logic [15:0] eb);
    int nb = 0;
    score_in = s;
    sb_q.push_back(eb);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      nb += int'(busy);
      if (n == 1) chk("busy_rise", busy, 1);
      if (n == 16) begin
        chk("busy_fall", busy, 0);
        chk("bcd_hold", bcd_out, prev_bcd);
      end
    end
    chk("busy_len", nb, 15);
    prev_bcd = eb;
  endtask

  task automatic scan_check(input logic [15:0] eb, input logic eo, input int cycles);
    int prev = -1, run = 0, nb = 0, idx;
    bit seen = 1'b0;
    logic [6:0] es;
    chk("bcd_scan", bcd_out, eb);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      nb += int'(busy);
      idx = dec(an);
      if (idx < 0) begin
        chk("an_onehot", an, 4'b1110);
        continue;
      end
      if (idx != prev) begin
        if (prev >= 0) begin
          chk("an_rotate", idx, (prev + 1) % 4);
          if (seen) chk("an_dwell", run, 4);
          seen = 1'b1;
        end
        prev = idx;
        run  = 1;
      end else run++;
      es = (idx > 0 && (eb >> (4 * idx)) == 16'd0) ? 7'h7F : segtab[eb[4*idx +: 4]];
      chk($sformatf("seg_d%0d", idx), seg, es);
      chk($sformatf("dp_d%0d", idx), dp, (idx == 0 && eo) ? 1'b0 : 1'b1);
    end
    chk("busy_idle", nb, 0);
  endtask

  initial begin
    vecs[0] = '{16'd1234,  16'h1234, 1'b0};
    vecs[1] = '{16'd42,    16'h0042, 1'b0};
    vecs[2] = '{16'd12345, 16'h9999, 1'b1};
    vecs[3] = '{16'd0,     16'h0000, 1'b0};
    vecs[4] = '{16'd9999,  16'h9999, 1'b0};
    vecs[5] = '{16'd10000, 16'h9999, 1'b1};
    vecs[6] = '{16'd65535, 16'h9999, 1'b1};
    vecs[7] = '{16'd100,   16'h0100, 1'b0};
    vecs[8] = '{16'd1,     16'h0001, 1'b0};
    vecs[9] = '{16'd8080,  16'h8080, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1);
    chk("rst_bcd", bcd_out, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    scan_check(16'h0000, 1'b0, 24);

    foreach (vecs[i]) begin
      convert(vecs[i].score, vecs[i].bcd);
      scan_check(vecs[i].bcd, vecs[i].ovf, 24);
    end

    // A change arriving mid-conversion is converted once the first finishes.
    score_in = 16'd7;
    sb_q.push_back(16'h0007);
    repeat (5) @(negedge clk);
    score_in = 16'd58;
    sb_q.push_back(16'h0058);
    repeat (40) @(negedge clk);
    chk("bcd_last_wins", bcd_out, 16'h0058);
    prev_bcd = 16'h0058;
    scan_check(16'h0058, 1'b0, 24);

    // Reset aborts a conversion in flight; the same score restarts afterwards.
    score_in = 16'd1234;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_an", an, 4'b1111);
    chk("abort_seg", seg, 7'h7F);
    chk("abort_dp", dp, 1);
    chk("abort_bcd", bcd_out, 0);
    chk("abort_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("abort_bcd_held", bcd_out, 0);
    reset = 1'b0;
    prev_bcd = '0;
    convert(16'd1234, 16'h1234);
    scan_check(16'h1234, 1'b0, 24);

    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
